// File: rtl/fetch_decode.sv
// Fetch / IF-ID stage: owns the PC, reads instruction memory combinationally and
// registers each fetched word together with its decoded opcode, register fields and immediate.
module fetch_decode #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic                id_valid,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [31:0]         id_instr,
  output logic [3:0]          id_opcode,
  output logic [4:0]          id_rd,
  output logic [4:0]          id_rn,
  output logic [4:0]          id_rm,
  output logic [PC_WIDTH-1:0] id_imm
);

  typedef enum logic [3:0] {
    OP_ADDI = 4'd1,
    OP_ADDS = 4'd2,
    OP_BLT  = 4'd3,
    OP_B    = 4'd4,
    OP_CBZ  = 4'd5,
    OP_LDUR = 4'd6,
    OP_LSL  = 4'd7,
    OP_LSR  = 4'd8,
    OP_MUL  = 4'd9,
    OP_STUR = 4'd10,
    OP_SUBS = 4'd11,
    OP_INV  = 4'd12
  } opcode_t;

  logic [PC_WIDTH-1:0] pc;
  opcode_t             dec_op;
  logic [PC_WIDTH-1:0] dec_imm;

  assign imem_addr = pc;

  // Decode ahead of the IF/ID register so id_* carry no combinational path from imem_data.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    dec_op  = OP_INV;
    dec_imm = '0;
    if (imem_data[31:21] == 11'b10101011000) begin
      dec_op = OP_ADDS;
    end else if (imem_data[31:21] == 11'b11101011000) begin
      dec_op = OP_SUBS;
    end else if (imem_data[31:21] == 11'b11111000010) begin
      dec_op  = OP_LDUR;
      dec_imm = {{(PC_WIDTH-9){imem_data[20]}}, imem_data[20:12]};
    end else if (imem_data[31:21] == 11'b11111000000) begin
      dec_op  = OP_STUR;
      dec_imm = {{(PC_WIDTH-9){imem_data[20]}}, imem_data[20:12]};
    end else if (imem_data[31:21] == 11'b10011011000) begin
      dec_op = OP_MUL;
    end else if (imem_data[31:21] == 11'b11010011011) begin
      dec_op  = OP_LSL;
      dec_imm = {{(PC_WIDTH-6){1'b0}}, imem_data[15:10]};
    end else if (imem_data[31:21] == 11'b11010011010) begin
      dec_op  = OP_LSR;
      dec_imm = {{(PC_WIDTH-6){1'b0}}, imem_data[15:10]};
    end else if (imem_data[31:22] == 10'b1001000100) begin
      dec_op  = OP_ADDI;
      dec_imm = {{(PC_WIDTH-12){1'b0}}, imem_data[21:10]};
    end else if (imem_data[31:24] == 8'b10110100) begin
      dec_op  = OP_CBZ;
      dec_imm = {{(PC_WIDTH-19){imem_data[23]}}, imem_data[23:5]};
    end else if (imem_data[31:24] == 8'b01010100) begin
      // Only the LT condition is supported; other B.cond encodings stay INV with a zero immediate.
      if (imem_data[4:0] == 5'b01011) begin
        dec_op  = OP_BLT;
        dec_imm = {{(PC_WIDTH-19){imem_data[23]}}, imem_data[23:5]};
      end
    end else if (imem_data[31:26] == 6'b000101) begin
      dec_op  = OP_B;
      dec_imm = {{(PC_WIDTH-26){imem_data[25]}}, imem_data[25:0]};
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_instr  <= '0;
      id_opcode <= OP_INV;
      id_rd     <= '0;
      id_rn     <= '0;
      id_rm     <= '0;
      id_imm    <= '0;
    end else if (redirect) begin
      // Flush the slot but keep id_pc; redirect wins over a simultaneous stall.
      pc        <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_opcode <= OP_INV;
      id_rd     <= '0;
      id_rn     <= '0;
      id_rm     <= '0;
      id_imm    <= '0;
    end else if (!stall) begin
      pc        <= pc + PC_WIDTH'(4);
      id_valid  <= 1'b1;
      id_pc     <= pc;
      id_instr  <= imem_data;
      id_opcode <= dec_op;
      id_rd     <= imem_data[4:0];
      id_rn     <= imem_data[9:5];
      id_rm     <= imem_data[20:16];
      id_imm    <= dec_imm;
    end
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front-end stage of the single-issue LEGv8-subset core. Holds the PC, drives the instruction-memory address, and registers each fetched 32-bit instruction into an IF/ID pipeline register. From that register it produces the 4-bit internal opcode consumed by the control decoder, plus register-field and immediate outputs. Supports stall (hold) and redirect (branch taken → flush one slot).

## Interface
- PC_WIDTH, 64, width of PC and immediate outputs
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID register
- redirect  in  1  branch taken; load redirect_pc and flush IF/ID
- redirect_pc  in  PC_WIDTH  branch target
- imem_addr  out  PC_WIDTH  current PC, combinational from PC register
- imem_data  in  32  instruction at imem_addr, combinational read
- id_valid  out  1  IF/ID slot holds a real instruction
- id_pc  out  PC_WIDTH  PC of instruction in IF/ID
- id_instr  out  32  raw instruction in IF/ID
- id_opcode  out  4  internal opcode: 1 ADDI, 2 ADDS, 3 BLT, 4 B, 5 CBZ, 6 LDUR, 7 LSL, 8 LSR, 9 MUL, 10 STUR, 11 SUBS, 12 INV
- id_rd, id_rn, id_rm  out  5 each  instr[4:0], instr[9:5], instr[20:16]
- id_imm  out  PC_WIDTH  extended immediate, per class below

## Operation
- PC register is the only fetch state. imem_addr = PC.
- Decode is performed on imem_data before registering. Match order, first hit wins:
  - [31:21]: 10101011000 ADDS; 11101011000 SUBS; 11111000010 LDUR; 11111000000 STUR; 10011011000 MUL; 11010011011 LSL; 11010011010 LSR.
  - [31:22] 1001000100 ADDI.
  - [31:24] 10110100 CBZ.
  - [31:24] 01010100 with [4:0]=01011 BLT. Any other cond is INV.
  - [31:26] 000101 B.
  - Anything else: INV (12).
- id_imm:
  - ADDI: zero-extended [21:10].
  - LDUR/STUR: sign-extended [20:12].
  - B: sign-extended [25:0].
  - CBZ/BLT: sign-extended [23:5].
  - LSL/LSR: zero-extended [15:10].
  - Else: 0.
  - Branch offsets are in words, unshifted.
- Bubble: id_valid=0, id_opcode=12, id_instr=0, id_imm=0, id_rd/rn/rm=0. id_pc holds its previous value.
- Per edge, in priority order:
  1. reset: PC←RESET_PC; IF/ID←bubble; id_pc←0.
  2. redirect: PC←{redirect_pc[PC_WIDTH-1:2],2'b00}; IF/ID←bubble.
  3. stall: PC and IF/ID hold.
  4. else: IF/ID←{1, PC, imem_data, decoded fields}; PC←PC+4.
- PC+4 wraps modulo 2^PC_WIDTH.
- Redirect and stall asserted together: redirect wins, and the flush still occurs.

## Timing
- Fetch-to-ID latency is 1 cycle. Decoded outputs are registered, so there is no combinational path from imem_data to id_*.
- Reset values: imem_addr=RESET_PC, id_valid=0, id_opcode=12, id_pc=0, id_instr=0, id_imm=0, id_rd/rn/rm=0.
- First valid instruction: the edge after reset deasserts loads instruction at RESET_PC. id_valid=1 is visible in the following cycle.
- Redirect at edge N: the instruction at redirect_pc appears in ID after edge N+1. Exactly one bubble is inserted.
- Stall for k cycles: id_* and imem_addr are stable for k cycles. No instruction is lost or duplicated.
- Reset asserted mid-stream overrides stall and redirect on that edge.

## Test plan
- Reset, then free-run over imem {ADDI X1,X31,#5 ; ADDS ; B +2}:
  - imem_addr goes 0,4,8.
  - ID yields opcode 1 (imm=5, rd=1, rn=31), then opcode 2, then opcode 4 (imm=2).
  - The first id_valid=1 occurs 1 cycle after reset release.
- Decode sweep of each listed encoding plus B.EQ (cond 00000) and 0x00000000:
  - Each listed encoding gives codes 1–11 with correct id_imm.
  - LDUR DT=-8 gives imm=0xFFFF_FFFF_FFFF_FFF8.
  - B.EQ and 0x00000000 give 12.
- Stall 3 cycles mid-stream:
  - imem_addr and id_* are frozen for 3 cycles.
  - After release, the next instruction follows with no duplicate.
- Redirect to 0x43 at PC=0x10:
  - Next cycle id_valid=0, id_opcode=12, imem_addr=0x40.
  - The cycle after, id_pc=0x40.
- Redirect plus stall in the same cycle: the flush occurs and the PC loads the target.
- PC=0xFFFF_FFFF_FFFF_FFFC, no stall: the next imem_addr is 0.
- Reset during stall: all outputs take reset values at the next edge.
